// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-holding arbiter that shares one dcfifo write port among NREQ producers.
// Optional macro ARB_MAXBURST_EN: force a grant release after MAXBURST accepted beats.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 16,
  parameter int IWIDTH   = $clog2(NREQ),
  parameter int MAXBURST = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       vld,
  input  logic [NREQ-1:0]       last,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rdy,
  output logic [IWIDTH-1:0]     owner,
  output logic                  busy,
  output logic [WIDTH-1:0]      fifo_data,
  output logic                  fifo_write,
  input  logic                  fifo_full
);

  localparam int CW = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXBURST);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t              r_state;
  logic [NREQ-1:0]     r_gnt;
  logic [IWIDTH-1:0]   r_owner;
  logic [IWIDTH-1:0]   r_ptr;
  logic                r_busy;
  logic [CW-1:0]       r_cnt;

  logic                w_acc;
  logic                w_limit;
  logic                w_release;
  logic [IWIDTH-1:0]   w_next_ptr;
  logic [IWIDTH-1:0]   w_start;
  logic                w_pick_vld;
  logic [IWIDTH-1:0]   w_pick_idx;
  logic [NREQ-1:0]     w_pick_gnt;
  logic [WIDTH-1:0]    w_fifo_data;

  // First set bit of r at or after start, wrapping; MSB of the result flags a hit.
  function automatic logic [IWIDTH:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IWIDTH-1:0] start);
    logic [IWIDTH:0] res;
    int idx;
    res = {(IWIDTH+1){1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (r[idx]) res = {1'b1, IWIDTH'(idx)};
    end
    return res;
  endfunction

  assign w_acc      = r_busy & vld[r_owner] & ~fifo_full;
`ifdef ARB_MAXBURST_EN
  assign w_limit    = (r_cnt == (CNT_MAX - CW'(1)));
`else
  assign w_limit    = 1'b0;
`endif
  assign w_release  = w_acc & (last[r_owner] | w_limit);
  assign w_next_ptr = (r_owner == IWIDTH'(NREQ - 1)) ? IWIDTH'(0) : (r_owner + IWIDTH'(1));
  // Back-to-back re-arbitration scans from owner+1, not from the stale pointer.
  assign w_start    = (r_state == S_BURST) ? w_next_ptr : r_ptr;
  assign {w_pick_vld, w_pick_idx} = rr_pick(req, w_start);
  assign w_pick_gnt = {{(NREQ-1){1'b0}}, 1'b1} << w_pick_idx;

  // Combinational data mux from the current owner onto the FIFO data bus.
  always_comb begin
    w_fifo_data = data[0 +: WIDTH];
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == IWIDTH'(i)) w_fifo_data = data[i*WIDTH +: WIDTH];
      else                       w_fifo_data = w_fifo_data;
    end
  end

  // Grant state machine: owner, grant, pointer and beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= {NREQ{1'b0}};
      r_owner <= {IWIDTH{1'b0}};
      r_ptr   <= {IWIDTH{1'b0}};
      r_busy  <= 1'b0;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= {CW{1'b0}};
          if (w_pick_vld) begin
            r_state <= S_BURST;
            r_owner <= w_pick_idx;
            r_gnt   <= w_pick_gnt;
            r_busy  <= 1'b1;
          end else begin
            r_gnt   <= {NREQ{1'b0}};
            r_owner <= {IWIDTH{1'b0}};
            r_busy  <= 1'b0;
          end
        end
        S_BURST: begin
          if (w_release) begin
            r_ptr <= w_next_ptr;
            r_cnt <= {CW{1'b0}};
            if (w_pick_vld) begin
              r_owner <= w_pick_idx;
              r_gnt   <= w_pick_gnt;
            end else begin
              r_state <= S_IDLE;
              r_gnt   <= {NREQ{1'b0}};
              r_owner <= {IWIDTH{1'b0}};
              r_busy  <= 1'b0;
            end
          end else if (w_acc) begin
            r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CW'(1));
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= {NREQ{1'b0}};
          r_owner <= {IWIDTH{1'b0}};
          r_ptr   <= {IWIDTH{1'b0}};
          r_busy  <= 1'b0;
          r_cnt   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign owner      = r_owner;
  assign busy       = r_busy;
  assign rdy        = r_gnt & ~{NREQ{fifo_full}};
  assign fifo_write = w_acc;
  assign fifo_data  = w_fifo_data;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers replay directed beat queues,
// a negedge monitor compares every FIFO write against hand-ordered expectations.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [NREQ-1:0]       req, vld, last, gnt, rdy;
  logic [NREQ*WIDTH-1:0] data;
  logic [IW-1:0]         owner;
  logic                  busy, fifo_write, fifo_full;
  logic [WIDTH-1:0]      fifo_data;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXBURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .vld(vld), .last(last), .data(data),
    .gnt(gnt), .rdy(rdy), .owner(owner), .busy(busy),
    .fifo_data(fifo_data), .fifo_write(fifo_write), .fifo_full(fifo_full)
  );

  typedef struct packed { logic [IW-1:0] own; logic [WIDTH-1:0] d; } exp_t;
  exp_t            exp_q[$];
  exp_t            mon_e;
  logic [WIDTH:0]  bq[NREQ][$];
  logic [NREQ-1:0] acc;
  logic            full_nx, rst_nx;
  int              n_pass = 0;
  int              n_total = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
  endfunction

  task automatic ld(input int i, input logic [WIDTH-1:0] d, input logic l);
    bq[i].push_back({l, d});
  endtask

  task automatic ex(input logic [IW-1:0] o, input logic [WIDTH-1:0] d);
    exp_t t;
    t.own = o;
    t.d = d;
    exp_q.push_back(t);
  endtask

  function automatic logic pending();
    for (int i = 0; i < NREQ; i++) if (bq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Producer model: req drops once the final last beat is on the bus under grant.
  task automatic drive();
    req = '0; vld = '0; last = '0; data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bq[i].size() > 0) begin
        vld[i] = 1'b1;
        data[i*WIDTH +: WIDTH] = bq[i][0][WIDTH-1:0];
        last[i] = bq[i][0][WIDTH];
        req[i] = !(bq[i].size() == 1 && bq[i][0][WIDTH] && gnt[i]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) if (acc[i] && bq[i].size() > 0) void'(bq[i].pop_front());
    fifo_full = full_nx;
    rst_n = rst_nx;
    if (!rst_nx) for (int i = 0; i < NREQ; i++) bq[i].delete();
    drive();
    @(negedge clk);
    acc = rdy & vld;
  endtask

  task automatic run_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || pending()) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  // Monitor: grant one-hot every cycle, each FIFO write popped from the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (fifo_write) begin
        if (exp_q.size() == 0) begin
          check("write_with_empty_scoreboard", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_owner", 32'(owner), 32'(mon_e.own));
          check("wr_data", 32'(fifo_data), 32'(mon_e.d));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rst_nx = 1'b0; fifo_full = 1'b0; full_nx = 1'b0;
    req = '0; vld = '1; last = '0; acc = '0;
    data = 64'h0000_0000_1234_5A5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_fifo_write", 32'(fifo_write), 32'd0);
    check("rst_fifo_data", 32'(fifo_data), 32'h5A5A);
    rst_nx = 1'b1;
    step();

    // Requester 0 three beats while 2 waits: 1-cycle grant, no bubble on hand-over.
    ld(0, 16'h00A0, 1'b0); ld(0, 16'h00A1, 1'b0); ld(0, 16'h00A2, 1'b1);
    ld(2, 16'h00C0, 1'b0); ld(2, 16'h00C1, 1'b1);
    ex(2'd0, 16'h00A0); ex(2'd0, 16'h00A1); ex(2'd0, 16'h00A2);
    ex(2'd2, 16'h00C0); ex(2'd2, 16'h00C1);
    step();
    check("s1_gnt_before_latency", 32'(gnt), 32'd0);
    step();
    check("s1_gnt0", 32'(gnt), 32'b0001);
    check("s1_rdy0", 32'(rdy), 32'b0001);
    step(); step(); step();
    check("s1_gnt2_no_bubble", 32'(gnt), 32'b0100);
    check("s1_busy_no_bubble", 32'(busy), 32'd1);
    run_idle("s1_done", 20);

    // FIFO full for five cycles in the middle of requester 2's burst.
    for (int k = 0; k < 4; k++) begin
      ld(2, 16'h2F00 + 16'(k), (k == 3));
      ex(2'd2, 16'h2F00 + 16'(k));
    end
    step(); step(); step();
    full_nx = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("s3_full_rdy2", 32'(rdy[2]), 32'd0);
      check("s3_full_write", 32'(fifo_write), 32'd0);
      check("s3_full_gnt", 32'(gnt), 32'b0100);
    end
    full_nx = 1'b0;
    step();
    check("s3_resume_write", 32'(fifo_write), 32'd1);
    run_idle("s3_done", 20);

    // Requester 1 alone with two back-to-back packets: re-granted without idle.
    ld(1, 16'h1B00, 1'b0); ld(1, 16'h1B01, 1'b1); ld(1, 16'h1B02, 1'b0); ld(1, 16'h1B03, 1'b1);
    for (int k = 0; k < 4; k++) ex(2'd1, 16'h1B00 + 16'(k));
    step();
    check("s4_idle_first", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("s4_busy_held", 32'(busy), 32'd1);
      check("s4_gnt1_held", 32'(gnt), 32'b0010);
    end
    step();
    check("s4_idle_after", 32'(busy), 32'd0);
    run_idle("s4_done", 10);

    // Reset pulse in the middle of requester 3's burst, then all four request.
    for (int k = 0; k < 4; k++) ld(3, 16'h3D00 + 16'(k), (k == 3));
    ex(2'd3, 16'h3D00); ex(2'd3, 16'h3D01);
    step(); step(); step();
    rst_nx = 1'b0;
    step();
    rst_nx = 1'b1;
    step();
    check("s5_rst_gnt", 32'(gnt), 32'd0);
    check("s5_rst_busy", 32'(busy), 32'd0);
    check("s5_rst_owner", 32'(owner), 32'd0);
    for (int k = 0; k < 4; k++) begin
      ld(k, 16'h0E00 + 16'(k), 1'b1);
      ex(2'(k), 16'h0E00 + 16'(k));
    end
    step(); step();
    check("s5_first_gnt0", 32'(gnt), 32'b0001);
    run_idle("s5_done", 20);

    // All four requesting, two-beat bursts, requester 0 twice: order 0,1,2,3,0.
    ld(0, 16'h0100, 1'b0); ld(0, 16'h0101, 1'b1); ld(0, 16'h0110, 1'b0); ld(0, 16'h0111, 1'b1);
    ld(1, 16'h1100, 1'b0); ld(1, 16'h1101, 1'b1);
    ld(2, 16'h2100, 1'b0); ld(2, 16'h2101, 1'b1);
    ld(3, 16'h3100, 1'b0); ld(3, 16'h3101, 1'b1);
    ex(2'd0, 16'h0100); ex(2'd0, 16'h0101); ex(2'd1, 16'h1100); ex(2'd1, 16'h1101);
    ex(2'd2, 16'h2100); ex(2'd2, 16'h2101); ex(2'd3, 16'h3100); ex(2'd3, 16'h3101);
    ex(2'd0, 16'h0110); ex(2'd0, 16'h0111);
    run_idle("s2_done", 30);

    // Requester 0 sends ten beats while requester 1 also wants the port.
    for (int k = 0; k < 10; k++) ld(0, 16'h4700 + 16'(k), (k == 9));
    step(); step();
    check("s6_gnt0", 32'(gnt), 32'b0001);
    ld(1, 16'h5100, 1'b0); ld(1, 16'h5101, 1'b1);
`ifdef ARB_MAXBURST_EN
    for (int k = 0; k < 4; k++) ex(2'd0, 16'h4700 + 16'(k));
    ex(2'd1, 16'h5100); ex(2'd1, 16'h5101);
    for (int k = 4; k < 10; k++) ex(2'd0, 16'h4700 + 16'(k));
`else
    for (int k = 0; k < 10; k++) ex(2'd0, 16'h4700 + 16'(k));
    ex(2'd1, 16'h5100); ex(2'd1, 16'h5101);
`endif
    run_idle("s6_done", 60);

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
